// File: rtl/dtw_pkg.sv
// Shared definitions for the delay/tap word blocks.
//   DTW_WIDTH  : default data word width in bits.
//   clog2_min1 : ceil(log2(n)) clamped to a minimum of 1, used to size
//                select and count ports so they never collapse to zero bits.
package dtw_pkg;

    localparam int DTW_WIDTH = 96;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tap_cache_stage.sv
// One delay stage: a WIDTH-bit data register plus its valid flag.
//   clk, rst : clock, asynchronous active-high reset
//   ld       : capture d/v on the next rising edge
//   clr      : zero data and valid on the next rising edge (wins over ld)
//   d, v     : incoming data word and its valid flag
//   q, q_vld : registered data word and valid flag
module tap_cache_stage
    import dtw_pkg::*;
#(
    parameter int WIDTH = DTW_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             v,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clr) begin
            data_d = '0;
            vld_d  = 1'b0;
        end else if (ld) begin
            data_d = d;
            vld_d  = v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q     = data_q;
    assign q_vld = vld_q;

endmodule

// File: rtl/tap_cache.sv
// Tapped delay line of DEPTH word stages with per-stage valid flags,
// a random-access read port and a running count of valid stages.
//   clk, rst          : clock, asynchronous active-high reset
//   ena               : global update enable (gates clear and shift alike)
//   clr               : synchronous clear of data, valid flags and count
//   in_valid, din     : incoming word; an idle cycle holds (BUBBLE=0) or
//                       shifts in an invalid zero word (BUBBLE=1)
//   taps, tap_valid   : all stages, stage 0 newest at bits [WIDTH-1:0]
//   rd_sel            : tap select; out-of-range selects read as zero/invalid
//   rd_data, rd_valid : selected tap and its valid flag (combinational)
//   count, full       : number of valid stages, count==DEPTH
//   out_valid         : valid flag of the oldest stage
module tap_cache
    import dtw_pkg::*;
#(
    parameter int WIDTH  = DTW_WIDTH,
    parameter int DEPTH  = 2,
    parameter int BUBBLE = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ena,
    input  logic                              clr,
    input  logic                              in_valid,
    input  logic [WIDTH-1:0]                  din,
    output logic [DEPTH*WIDTH-1:0]            taps,
    output logic [DEPTH-1:0]                  tap_valid,
    input  logic [clog2_min1(DEPTH)-1:0]      rd_sel,
    output logic [WIDTH-1:0]                  rd_data,
    output logic                              rd_valid,
    output logic [clog2_min1(DEPTH+1)-1:0]    count,
    output logic                              full,
    output logic                              out_valid
);

    localparam int CNTW = clog2_min1(DEPTH + 1);

    logic                        shift, clr_en;
    logic [DEPTH-1:0][WIDTH-1:0] stg_d, stg_q;
    logic [DEPTH-1:0]            stg_vin, stg_vq;
    logic [CNTW-1:0]             count_q, count_d;

    // clr outranks a shift; both are dead while ena is low.
    assign clr_en = ena & clr;
    assign shift  = ena & ~clr & (in_valid | (BUBBLE != 0));

    genvar k;
    for (k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            // An idle bubble enters as an all-zero word.
            assign stg_d[k]   = in_valid ? din : '0;
            assign stg_vin[k] = in_valid;
        end else begin : g_body
            assign stg_d[k]   = stg_q[k-1];
            assign stg_vin[k] = stg_vq[k-1];
        end

        tap_cache_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .ld    (shift),
            .clr   (clr_en),
            .d     (stg_d[k]),
            .v     (stg_vin[k]),
            .q     (stg_q[k]),
            .q_vld (stg_vq[k])
        );
    end

    // Count tracks valid words entering stage 0 versus leaving the last
    // stage; the bounds checks keep it from ever wrapping.
    always_comb begin
        count_d = count_q;
        if (clr_en) begin
            count_d = '0;
        end else if (shift) begin
            if (in_valid && !stg_vq[DEPTH-1] && count_q != CNTW'(DEPTH))
                count_d = count_q + 1'b1;
            else if (!in_valid && stg_vq[DEPTH-1] && count_q != '0)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    // Random-access read; a single-stage build ignores rd_sel entirely.
    logic unused_sel;
    assign unused_sel = ^rd_sel;

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (DEPTH == 1 || int'(rd_sel) == i) begin
                rd_data  = stg_q[i];
                rd_valid = stg_vq[i];
            end
        end
    end

    assign taps      = stg_q;
    assign tap_valid = stg_vq;
    assign count     = count_q;
    assign full      = (count_q == CNTW'(DEPTH));
    assign out_valid = stg_vq[DEPTH-1];

endmodule

// File: tb/tb_tap_cache.sv
module tb_tap_cache;

    // Five builds share the same stimulus: 0:D2/hold 1:D2/bubble 2:D4/bubble
    // 3:D3/hold 4:D1/bubble.
    localparam int NI = 5;
    localparam int DEP  [NI] = '{2, 2, 4, 3, 1};
    localparam int BUB  [NI] = '{0, 1, 1, 0, 1};
    localparam int SELW [NI] = '{1, 1, 2, 2, 1};

    logic clk = 1'b0;
    logic rst, ena, clr, in_valid;
    logic [95:0] din;
    logic [1:0]  sel;

    logic [191:0] t0, t1;  logic [1:0] v0, v1;  logic [1:0] c0, c1;
    logic [383:0] t2;      logic [3:0] v2;      logic [2:0] c2;
    logic [287:0] t3;      logic [2:0] v3;      logic [1:0] c3;
    logic [95:0]  t4;      logic [0:0] v4;      logic [0:0] c4;
    logic [95:0]  r0, r1, r2, r3, r4;
    logic rv0, rv1, rv2, rv3, rv4, f0, f1, f2, f3, f4, ov0, ov1, ov2, ov3, ov4;

    always #5 clk = ~clk;

    tap_cache #(.DEPTH(2), .BUBBLE(0)) u_d2h (.clk(clk), .rst(rst), .ena(ena), .clr(clr),
        .in_valid(in_valid), .din(din), .taps(t0), .tap_valid(v0), .rd_sel(sel[0:0]),
        .rd_data(r0), .rd_valid(rv0), .count(c0), .full(f0), .out_valid(ov0));
    tap_cache #(.DEPTH(2), .BUBBLE(1)) u_d2b (.clk(clk), .rst(rst), .ena(ena), .clr(clr),
        .in_valid(in_valid), .din(din), .taps(t1), .tap_valid(v1), .rd_sel(sel[0:0]),
        .rd_data(r1), .rd_valid(rv1), .count(c1), .full(f1), .out_valid(ov1));
    tap_cache #(.DEPTH(4), .BUBBLE(1)) u_d4 (.clk(clk), .rst(rst), .ena(ena), .clr(clr),
        .in_valid(in_valid), .din(din), .taps(t2), .tap_valid(v2), .rd_sel(sel),
        .rd_data(r2), .rd_valid(rv2), .count(c2), .full(f2), .out_valid(ov2));
    tap_cache #(.DEPTH(3), .BUBBLE(0)) u_d3 (.clk(clk), .rst(rst), .ena(ena), .clr(clr),
        .in_valid(in_valid), .din(din), .taps(t3), .tap_valid(v3), .rd_sel(sel),
        .rd_data(r3), .rd_valid(rv3), .count(c3), .full(f3), .out_valid(ov3));
    tap_cache #(.DEPTH(1), .BUBBLE(1)) u_d1 (.clk(clk), .rst(rst), .ena(ena), .clr(clr),
        .in_valid(in_valid), .din(din), .taps(t4), .tap_valid(v4), .rd_sel(sel[0:0]),
        .rd_data(r4), .rd_valid(rv4), .count(c4), .full(f4), .out_valid(ov4));

    // Observed outputs gathered per build for uniform indexing.
    logic [95:0] o_tap [NI][4];
    logic        o_tv  [NI][4];
    logic [6:0]  o_cnt [NI];
    logic [95:0] o_rd  [NI];
    logic        o_rv  [NI], o_full [NI], o_ov [NI];

    always_comb begin
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 4; k++) begin
                o_tap[i][k] = '0;
                o_tv[i][k]  = 1'b0;
            end
        for (int k = 0; k < 2; k++) begin
            o_tap[0][k] = t0[k*96 +: 96]; o_tv[0][k] = v0[k];
            o_tap[1][k] = t1[k*96 +: 96]; o_tv[1][k] = v1[k];
        end
        for (int k = 0; k < 4; k++) begin
            o_tap[2][k] = t2[k*96 +: 96]; o_tv[2][k] = v2[k];
        end
        for (int k = 0; k < 3; k++) begin
            o_tap[3][k] = t3[k*96 +: 96]; o_tv[3][k] = v3[k];
        end
        o_tap[4][0] = t4; o_tv[4][0] = v4[0];
        o_cnt  = '{7'(c0), 7'(c1), 7'(c2), 7'(c3), 7'(c4)};
        o_rd   = '{r0, r1, r2, r3, r4};
        o_rv   = '{rv0, rv1, rv2, rv3, rv4};
        o_full = '{f0, f1, f2, f3, f4};
        o_ov   = '{ov0, ov1, ov2, ov3, ov4};
    end

    // Reference model: a plain list of words per build, newest at index 0.
    logic [95:0] m_data [NI][4];
    logic        m_vld  [NI][4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_clear();
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 4; k++) begin
                m_data[i][k] = '0;
                m_vld[i][k]  = 1'b0;
            end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
            return;
        end
        for (int i = 0; i < NI; i++) begin
            if (!ena) continue;
            if (clr) begin
                for (int k = 0; k < 4; k++) begin
                    m_data[i][k] = '0;
                    m_vld[i][k]  = 1'b0;
                end
            end else if (in_valid || BUB[i] != 0) begin
                for (int k = DEP[i] - 1; k > 0; k--) begin
                    m_data[i][k] = m_data[i][k-1];
                    m_vld[i][k]  = m_vld[i][k-1];
                end
                m_data[i][0] = in_valid ? din : '0;
                m_vld[i][0]  = in_valid;
            end
        end
    endtask

    function automatic int m_count(int i);
        int c = 0;
        for (int k = 0; k < DEP[i]; k++) c += int'(m_vld[i][k]);
        return c;
    endfunction

    function automatic int m_sel(int i);
        if (DEP[i] == 1) return 0;
        return (SELW[i] == 1) ? int'(sel[0]) : int'(sel);
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0; sel = '0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b1; in_valid = 1'b1;
        din = rnd96(); cyc();
        din = rnd96(); cyc();
        #2 rst = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (t0 !== '0 || v0 !== '0) begin
            n_bad++; $display("FAIL reset_taps: taps=%h valid=%b required 0", t0, v0);
        end
        n_cmp++;
        if (c0 !== '0 || f0 !== 1'b0 || ov0 !== 1'b0) begin
            n_bad++; $display("FAIL reset_count: count=%0d full=%b out_valid=%b required 0/0/0", c0, f0, ov0);
        end
        n_cmp++;
        if (t2 !== '0 || c2 !== '0) begin
            n_bad++; $display("FAIL reset_d4: taps=%h count=%0d required 0", t2, c2);
        end
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_fill_full();
        ena = 1'b1; clr = 1'b0; in_valid = 1'b1;
        din = 96'hA; cyc();
        n_cmp++;
        if (c0 !== 2'd1) begin
            n_bad++; $display("FAIL first_after_reset_count: count=%0d required 1", c0);
        end
        din = 96'hB; cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_tap[i][0] !== 96'hB || o_tap[i][1] !== 96'hA) begin
                n_bad++; $display("FAIL fill_taps[%0d]: s0=%h s1=%h required B/A", i, o_tap[i][0], o_tap[i][1]);
            end
            n_cmp++;
            if (o_cnt[i] !== 7'd2 || o_full[i] !== 1'b1 || o_ov[i] !== 1'b1) begin
                n_bad++; $display("FAIL fill_full[%0d]: count=%0d full=%b out_valid=%b required 2/1/1",
                                  i, o_cnt[i], o_full[i], o_ov[i]);
            end
        end
    endtask

    task automatic test_hold_bubble();
        ena = 1'b1; clr = 1'b0; in_valid = 1'b0; din = rnd96();
        cyc();
        n_cmp++;
        if (o_tap[0][0] !== 96'hB || o_tap[0][1] !== 96'hA || o_cnt[0] !== 7'd2 || v0 !== 2'b11) begin
            n_bad++; $display("FAIL hold: s0=%h s1=%h valid=%b count=%0d required B/A/11/2",
                              o_tap[0][0], o_tap[0][1], v0, o_cnt[0]);
        end
        n_cmp++;
        if (o_tap[1][0] !== '0 || o_tv[1][0] !== 1'b0 || o_tap[1][1] !== 96'hB || o_cnt[1] !== 7'd1) begin
            n_bad++; $display("FAIL bubble: s0=%h v0=%b s1=%h count=%0d required 0/0/B/1",
                              o_tap[1][0], o_tv[1][0], o_tap[1][1], o_cnt[1]);
        end
    endtask

    task automatic test_clear_priority();
        ena = 1'b1; clr = 1'b1; in_valid = 1'b0;
        cyc();
        clr = 1'b0; in_valid = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            din = 96'(j); cyc();
        end
        n_cmp++;
        if (o_cnt[2] !== 7'd3) begin
            n_bad++; $display("FAIL clr_setup_count: count=%0d required 3", o_cnt[2]);
        end
        clr = 1'b1; din = 96'h5;
        cyc();
        clr = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (t2 !== '0 || v2 !== '0 || c2 !== '0) begin
            n_bad++; $display("FAIL clr_priority: taps=%h valid=%b count=%0d required 0", t2, v2, c2);
        end
    endtask

    task automatic test_ena_gating();
        ena = 1'b1; clr = 1'b0; in_valid = 1'b1;
        din = 96'h11; cyc();
        din = 96'h22; cyc();
        ena = 1'b0; clr = 1'b1; din = 96'h33;
        for (int j = 0; j < 3; j++) begin
            cyc();
            n_cmp++;
            if (o_tap[2][0] !== 96'h22 || o_tap[2][1] !== 96'h11 || v2 !== 4'b0011 || c2 !== 3'd2) begin
                n_bad++; $display("FAIL ena_gate[%0d]: s0=%h s1=%h valid=%b count=%0d required 22/11/0011/2",
                                  j, o_tap[2][0], o_tap[2][1], v2, c2);
            end
        end
        ena = 1'b1; clr = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_random_access();
        logic [95:0] exp_rd;
        ena = 1'b1; clr = 1'b0; in_valid = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            din = 96'(j); cyc();
        end
        in_valid = 1'b0; ena = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            exp_rd = 96'(4 - s);
            n_cmp++;
            if (r2 !== exp_rd || rv2 !== 1'b1) begin
                n_bad++; $display("FAIL rd_sel_d4[%0d]: rd_data=%h rd_valid=%b required %h/1", s, r2, rv2, exp_rd);
            end
        end
        n_cmp++;
        if (r3 !== '0 || rv3 !== 1'b0) begin
            n_bad++; $display("FAIL rd_range_d3: rd_data=%h rd_valid=%b required 0/0", r3, rv3);
        end
        n_cmp++;
        if (r4 !== 96'h4 || rv4 !== 1'b1) begin
            n_bad++; $display("FAIL rd_d1_ignore_sel: rd_data=%h rd_valid=%b required 4/1", r4, rv4);
        end
        @(negedge clk);
        ena = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) < 2) begin
                rst = 1'b1; #1;
                model_clear();
                rst = 1'b0;
            end
            ena      = ($urandom_range(99) < 80);
            clr      = ($urandom_range(99) < 5);
            in_valid = ($urandom_range(99) < 60);
            din      = rnd96();
            sel      = 2'($urandom_range(3));
            cyc();
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < DEP[i]; k++) begin
                    n_cmp++;
                    if (o_tap[i][k] !== m_data[i][k] || o_tv[i][k] !== m_vld[i][k]) begin
                        n_bad++; $display("FAIL rand_tap[%0d][%0d] cyc %0d: %h/%b required %h/%b",
                                          i, k, n, o_tap[i][k], o_tv[i][k], m_data[i][k], m_vld[i][k]);
                    end
                end
                n_cmp++;
                if (o_cnt[i] !== 7'(m_count(i)) || o_full[i] !== (m_count(i) == DEP[i]) ||
                    o_ov[i] !== m_vld[i][DEP[i]-1]) begin
                    n_bad++; $display("FAIL rand_count[%0d] cyc %0d: count=%0d full=%b ov=%b required %0d",
                                      i, n, o_cnt[i], o_full[i], o_ov[i], m_count(i));
                end
                n_cmp++;
                if (m_sel(i) < DEP[i]) begin
                    if (o_rd[i] !== m_data[i][m_sel(i)] || o_rv[i] !== m_vld[i][m_sel(i)]) begin
                        n_bad++; $display("FAIL rand_rd[%0d] cyc %0d: %h/%b required %h/%b", i, n,
                                          o_rd[i], o_rv[i], m_data[i][m_sel(i)], m_vld[i][m_sel(i)]);
                    end
                end else if (o_rd[i] !== '0 || o_rv[i] !== 1'b0) begin
                    n_bad++; $display("FAIL rand_rd_range[%0d] cyc %0d: %h/%b required 0/0", i, n, o_rd[i], o_rv[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_hold_bubble();
        test_clear_priority();
        test_ena_gating();
        test_random_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
